// File: rtl/rsc_trellis_encoder.sv
// Recursive systematic convolutional encoder with trellis termination.
// Emits {parity, systematic} per info bit, then MEMORY tail symbols that return the state to zero.
module rsc_trellis_encoder #(
    parameter int              BITS        = 16,
    parameter string           PRECISION   = "HALF",
    parameter int              MEMORY      = 3,
    parameter logic [MEMORY:0] FB_POLY     = 4'b1101,
    parameter logic [MEMORY:0] FF_POLY     = 4'b1011,
    parameter int              MAX_FRAME   = 6144,
    parameter int              OUTPUT_BITS = 2,
    localparam int             IDX_W       = $clog2(MAX_FRAME + MEMORY)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_bit,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUTPUT_BITS-1:0]              out_bits,
    output logic [OUTPUT_BITS-1:0][BITS-1:0]    out_sym,
    output logic                                out_tail,
    output logic                                out_last,
    output logic [IDX_W-1:0]                    out_index,
    output logic [MEMORY-1:0]                   out_state
);

    localparam logic [BITS-1:0] SYM_POS = (PRECISION == "SINGLE") ? BITS'(32'h3F80_0000) : BITS'(16'h3C00);
    localparam logic [BITS-1:0] SYM_NEG = (PRECISION == "SINGLE") ? BITS'(32'hBF80_0000) : BITS'(16'hBC00);
    localparam int              TAIL_W   = $clog2(MEMORY + 1);
    localparam logic [TAIL_W-1:0] TAIL_END = TAIL_W'(MEMORY - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(MAX_FRAME + MEMORY - 1);

    typedef enum logic {ST_DATA, ST_TAIL} fsm_t;

    fsm_t                              fsm_q, fsm_d;
    logic [MEMORY-1:0]                 s_q, s_d;
    logic [TAIL_W-1:0]                 tail_cnt_q, tail_cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic                              out_valid_q, out_valid_d;
    logic [OUTPUT_BITS-1:0]            out_bits_q, out_bits_d;
    logic [OUTPUT_BITS-1:0][BITS-1:0]  out_sym_q, out_sym_d;
    logic                              out_tail_q, out_tail_d;
    logic                              out_last_q, out_last_d;
    logic [IDX_W-1:0]                  out_index_q, out_index_d;
    logic [MEMORY-1:0]                 out_state_q, out_state_d;

    logic advance, fire, tail_done;
    logic fb, ff_taps, u, a, parity;

    always_comb begin
        advance  = !out_valid_q || out_ready;
        in_ready = (fsm_q == ST_DATA) && advance;

        fb      = 1'b0;
        ff_taps = 1'b0;
        for (int i = 0; i < MEMORY; i++) begin
            fb      = fb ^ (FB_POLY[i+1] & s_q[i]);
            ff_taps = ff_taps ^ (FF_POLY[i+1] & s_q[i]);
        end

        // During the tail the input is forced to the feedback so the shifted-in bit is zero.
        u         = (fsm_q == ST_TAIL) ? fb : in_bit;
        a         = u ^ fb;
        parity    = (FF_POLY[0] & a) ^ ff_taps;
        fire      = (fsm_q == ST_TAIL) ? advance : (in_valid && in_ready);
        tail_done = (fsm_q == ST_TAIL) && (tail_cnt_q == TAIL_END);

        fsm_d       = fsm_q;
        s_d         = s_q;
        tail_cnt_d  = tail_cnt_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_sym_d   = out_sym_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        out_state_d = out_state_q;

        if (fire) begin
            s_d          = MEMORY'({s_q, a});
            out_valid_d  = 1'b1;
            out_bits_d   = OUTPUT_BITS'({parity, u});
            out_sym_d[0] = u ? SYM_NEG : SYM_POS;
            out_sym_d[1] = parity ? SYM_NEG : SYM_POS;
            out_tail_d   = (fsm_q == ST_TAIL);
            out_last_d   = tail_done;
            out_index_d  = idx_q;
            out_state_d  = s_q;

            if (tail_done) begin
                idx_d = '0;
            end else if (idx_q != IDX_MAX) begin
                idx_d = idx_q + 1'b1;
            end

            if (fsm_q == ST_DATA) begin
                if (in_last) begin
                    fsm_d      = ST_TAIL;
                    tail_cnt_d = '0;
                end
            end else if (tail_done) begin
                fsm_d      = ST_DATA;
                tail_cnt_d = '0;
            end else begin
                tail_cnt_d = tail_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_DATA;
            s_q         <= '0;
            tail_cnt_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_sym_q   <= {OUTPUT_BITS{SYM_POS}};
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            out_state_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            s_q         <= s_d;
            tail_cnt_q  <= tail_cnt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_sym_q   <= out_sym_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            out_state_q <= out_state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_sym   = out_sym_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_rsc_trellis_encoder.sv
// Directed and random checks of rsc_trellis_encoder: hand-computed frames, backpressure,
// back-to-back frames, reset mid-tail, and random frames against a small reference model.
module tb_rsc_trellis_encoder;

    localparam int IDXW = $clog2(6144 + 3);

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_bit;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_bits;
    logic [1:0][15:0]      out_sym;
    logic                  out_tail;
    logic                  out_last;
    logic [IDXW-1:0]       out_index;
    logic [2:0]            out_state;

    rsc_trellis_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_sym   (out_sym),
        .out_tail  (out_tail),
        .out_last  (out_last),
        .out_index (out_index),
        .out_state (out_state)
    );

    typedef struct packed {
        logic            valid;
        logic [1:0]      bits;
        logic [15:0]     sym1;
        logic [15:0]     sym0;
        logic            tail;
        logic            last;
        logic [IDXW-1:0] idx;
        logic [2:0]      st;
    } sym_t;

    typedef struct {
        logic       sys;
        logic       par;
        logic       tail;
        logic       last;
        int         idx;
        logic [2:0] st;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   readyMode = 0;
    logic inReadyNeg = 1'b0;
    logic prevStalled = 1'b0;
    sym_t prevSym;
    sym_t symQ[$];
    exp_t expQ[$];
    logic frameBits[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Samples outputs mid-cycle: records accepted symbols and checks that stalled outputs hold.
    always @(negedge clk) begin
        sym_t cur;
        cur = '{valid: out_valid, bits: out_bits, sym1: out_sym[1], sym0: out_sym[0],
                tail: out_tail, last: out_last, idx: out_index, st: out_state};
        inReadyNeg = in_ready;
        if (!rst) begin
            if (prevStalled)
                checkOutput("stall_hold", 64'(cur), 64'(prevSym));
            if (out_valid && !out_ready)
                checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready)
                symQ.push_back(cur);
        end
        prevStalled = !rst && out_valid && !out_ready;
        prevSym     = cur;
    end

    // Drives out_ready just after each rising edge: always ready, strict toggle, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       out_ready = ~out_ready;
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic loadBits(input logic [15:0] v, input int n);
        frameBits.delete();
        for (int i = 0; i < n; i++) frameBits.push_back(v[i]);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < frameBits.size(); i++) begin
            bit accepted = 1'b0;
            int guard = 0;
            in_valid = 1'b1;
            in_bit   = frameBits[i];
            in_last  = (i == frameBits.size() - 1);
            while (!accepted) begin
                @(posedge clk);
                accepted = inReadyNeg;
                #1;
                guard++;
                if (!accepted && guard > 200) begin
                    checkOutput("accept_timeout", 64'd0, 64'd1);
                    accepted = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    // After the last info bit, in_ready must stay low until the final tail symbol appears.
    task automatic waitTail();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_last) break;
            checkOutput("tail_in_ready", 64'(in_ready), 64'd0);
            guard++;
            if (guard > 100) begin
                checkOutput("tail_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic pushTable(input logic [15:0] sysV, input logic [15:0] parV,
                             input logic [47:0] stV, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.sys  = sysV[i];
            e.par  = parV[i];
            e.st   = stV[3*i +: 3];
            e.tail = (i >= n - 3);
            e.last = (i == n - 1);
            e.idx  = i;
            expQ.push_back(e);
        end
    endtask

    // Reference encoder straight from the recursion equations for taps 1+D^2+D^3 / 1+D+D^3.
    task automatic buildModel();
        logic [3:0] fbPoly = 4'b1101;
        logic [3:0] ffPoly = 4'b1011;
        logic [2:0] s = 3'd0;
        int n = frameBits.size();
        for (int i = 0; i < n + 3; i++) begin
            exp_t e;
            logic fb, u, a;
            fb     = ^(fbPoly[3:1] & s);
            u      = (i >= n) ? fb : frameBits[i];
            a      = u ^ fb;
            e.sys  = u;
            e.par  = (ffPoly[0] & a) ^ (^(ffPoly[3:1] & s));
            e.st   = s;
            e.tail = (i >= n);
            e.last = (i == n + 2);
            e.idx  = i;
            expQ.push_back(e);
            s = {s[1:0], a};
        end
        checkOutput("model_end_state", 64'(s), 64'd0);
    endtask

    task automatic compareFrames(input string tag);
        int guard = 0;
        while (symQ.size() < expQ.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        checkOutput($sformatf("%s.count", tag), 64'(symQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < symQ.size(); i++) begin
            checkOutput($sformatf("%s[%0d].bits", tag, i), 64'(symQ[i].bits), 64'({expQ[i].par, expQ[i].sys}));
            checkOutput($sformatf("%s[%0d].sym", tag, i), 64'({symQ[i].sym1, symQ[i].sym0}),
                        64'({expQ[i].par ? 16'hBC00 : 16'h3C00, expQ[i].sys ? 16'hBC00 : 16'h3C00}));
            checkOutput($sformatf("%s[%0d].tail", tag, i), 64'(symQ[i].tail), 64'(expQ[i].tail));
            checkOutput($sformatf("%s[%0d].last", tag, i), 64'(symQ[i].last), 64'(expQ[i].last));
            checkOutput($sformatf("%s[%0d].idx", tag, i), 64'(symQ[i].idx), 64'(expQ[i].idx));
            checkOutput($sformatf("%s[%0d].state", tag, i), 64'(symQ[i].st), 64'(expQ[i].st));
        end
        symQ.delete();
        expQ.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".bits"}, 64'(out_bits), 64'd0);
        checkOutput({tag, ".sym"}, 64'(out_sym), 64'h3C00_3C00);
        checkOutput({tag, ".tail"}, 64'(out_tail), 64'd0);
        checkOutput({tag, ".last"}, 64'(out_last), 64'd0);
        checkOutput({tag, ".idx"}, 64'(out_index), 64'd0);
        checkOutput({tag, ".state"}, 64'(out_state), 64'd0);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic runImpulse(input string tag);
        loadBits(16'h0001, 4);
        applyStimulus();
        waitTail();
        pushTable(16'h0051, 16'h007F, {3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0}, 7);
        compareFrames(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkReset("reset");

        runImpulse("impulse");

        loadBits(16'h0000, 8);
        applyStimulus();
        waitTail();
        pushTable(16'h0000, 16'h0000, 48'd0, 11);
        compareFrames("zeros");

        readyMode = 1;
        runImpulse("backpressure");
        readyMode = 0;

        loadBits(16'h0001, 4);
        applyStimulus();
        waitTail();
        loadBits(16'h0003, 2);
        applyStimulus();
        waitTail();
        pushTable(16'h0051, 16'h007F, {3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0}, 7);
        pushTable(16'h0017, 16'h001D, {3'd4, 3'd6, 3'd3, 3'd1, 3'd0}, 5);
        compareFrames("b2b");

        loadBits(16'h0001, 1);
        applyStimulus();
        waitTail();
        pushTable(16'h000D, 16'h000B, {3'd4, 3'd2, 3'd1, 3'd0}, 4);
        compareFrames("single");

        begin
            int guard = 0;
            loadBits(16'h0001, 4);
            applyStimulus();
            while (!(out_valid && out_tail) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("midtail_seen", 64'(out_valid && out_tail), 64'd1);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            checkReset("midtail_reset");
            symQ.delete();
            expQ.delete();
        end
        runImpulse("after_reset");

        readyMode = 2;
        for (int f = 0; f < 2; f++) begin
            frameBits.delete();
            for (int i = 0; i < 1000; i++) frameBits.push_back(1'($urandom_range(0, 1)));
            buildModel();
            applyStimulus();
            waitTail();
        end
        compareFrames("random");
        readyMode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
